// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
// Moore control FSM for a multicycle RV32I datapath built around a shared ALU,
// one unified memory port, a register file and a sign extender. Every
// instruction walks FETCH -> DECODE -> class-specific states. Memory waits are
// bounded, and illegal opcodes or branch encodings halt the core in TRAP.
//
// Parameters
//   MEM_WAIT_MAX  cycles a memory state may see mem_ready low before TRAP (1..255)
//   CNT_WIDTH     width of the retired-instruction counter
//
// Ports
//   clk, rst        clock; asynchronous active-high reset
//   op, funct3,     instruction fields (instr[6:0], instr[14:12], instr[30])
//   funct7
//   zero, negative  ALU status flags used by branch evaluation
//   mem_ready       memory completes the current access this cycle
//   mem_req         memory access request
//   MemWrite        request is a write
//   AdrSrc          address select: 0 PC, 1 ALUOut
//   IRWrite         load instruction register and oldPC
//   PCWrite         load PC from the result bus
//   RegWrite        register file write enable
//   ImmSrc          immediate format: 000 I, 001 S, 010 B, 011 J, 100 U
//   ALUSrcA         00 PC, 01 oldPC, 10 rd1, 11 zero
//   ALUSrcB         00 rd2, 01 ImmExt, 10 constant 4
//   ALUcontrol      0000 add, 0001 sub, 0010 sll, 0011 slt, 0100 sltu,
//                   0101 xor, 0110 srl, 0111 sra, 1000 or, 1001 and
//   ResultSrc       00 ALUOut, 01 memory data, 10 ALU result
//   halted          FSM is in TRAP
//   instret         retired-instruction count (wraps)
// ---------------------------------------------------------------------------
module multicycle_ctrl #(
    parameter int unsigned MEM_WAIT_MAX = 15,
    parameter int unsigned CNT_WIDTH    = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [6:0]           op,
    input  logic [2:0]           funct3,
    input  logic                 funct7,
    input  logic                 zero,
    input  logic                 negative,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 MemWrite,
    output logic                 AdrSrc,
    output logic                 IRWrite,
    output logic                 PCWrite,
    output logic                 RegWrite,
    output logic [2:0]           ImmSrc,
    output logic [1:0]           ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [3:0]           ALUcontrol,
    output logic [1:0]           ResultSrc,
    output logic                 halted,
    output logic [CNT_WIDTH-1:0] instret
);

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMREAD,
        MEMWB,
        MEMWRITE,
        EXEC_R,
        EXEC_I,
        EXEC_U,
        ALUWB,
        BRANCH,
        JAL,
        TRAP
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_SLL  = 4'b0010;
    localparam logic [3:0] ALU_SLT  = 4'b0011;
    localparam logic [3:0] ALU_SLTU = 4'b0100;
    localparam logic [3:0] ALU_XOR  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_OR   = 4'b1000;
    localparam logic [3:0] ALU_AND  = 4'b1001;

    localparam logic [7:0]           WAIT_LIMIT = MEM_WAIT_MAX[7:0];
    localparam logic [CNT_WIDTH-1:0] CNT_ONE    = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t     state;
    logic [7:0] wait_cnt;
    logic       mem_state;
    logic       mem_timeout;
    logic       taken;
    logic       branch_ok;

    // alt selects the second flavour of add/sub and srl/sra; other funct3
    // codes ignore it.
    function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic alt);
        logic [3:0] code;
        case (f3)
            3'b000:  code = alt ? ALU_SUB : ALU_ADD;
            3'b001:  code = ALU_SLL;
            3'b010:  code = ALU_SLT;
            3'b011:  code = ALU_SLTU;
            3'b100:  code = ALU_XOR;
            3'b101:  code = alt ? ALU_SRA : ALU_SRL;
            3'b110:  code = ALU_OR;
            default: code = ALU_AND;
        endcase
        return code;
    endfunction

    always_comb begin
        taken     = 1'b0;
        branch_ok = 1'b1;
        case (funct3)
            3'b000:  taken = zero;
            3'b001:  taken = !zero;
            3'b100:  taken = negative;
            3'b101:  taken = !negative;
            default: branch_ok = 1'b0;
        endcase
    end

    assign mem_state   = (state == FETCH) || (state == MEMREAD) || (state == MEMWRITE);
    // A ready in the limit cycle still completes the access.
    assign mem_timeout = !mem_ready && (wait_cnt == WAIT_LIMIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= FETCH;
            wait_cnt <= '0;
            instret  <= '0;
        end else begin
            // Counter only runs while a memory state is stalled; outside those
            // states it sits at zero, so every memory state starts fresh.
            if (mem_state && !mem_ready && !mem_timeout) begin
                wait_cnt <= wait_cnt + 8'd1;
            end else begin
                wait_cnt <= '0;
            end

            case (state)
                FETCH: begin
                    if (mem_ready) begin
                        state <= DECODE;
                    end else if (mem_timeout) begin
                        state <= TRAP;
                    end
                end
                DECODE: begin
                    case (op)
                        OP_LOAD:   state <= MEMADR;
                        OP_STORE:  state <= MEMADR;
                        OP_R:      state <= EXEC_R;
                        OP_I:      state <= EXEC_I;
                        OP_LUI:    state <= EXEC_U;
                        OP_BRANCH: state <= BRANCH;
                        OP_JAL:    state <= JAL;
                        default:   state <= TRAP;
                    endcase
                end
                MEMADR: begin
                    state <= (op == OP_STORE) ? MEMWRITE : MEMREAD;
                end
                MEMREAD: begin
                    if (mem_ready) begin
                        state <= MEMWB;
                    end else if (mem_timeout) begin
                        state <= TRAP;
                    end
                end
                MEMWB: begin
                    state   <= FETCH;
                    instret <= instret + CNT_ONE;
                end
                MEMWRITE: begin
                    if (mem_ready) begin
                        state   <= FETCH;
                        instret <= instret + CNT_ONE;
                    end else if (mem_timeout) begin
                        state <= TRAP;
                    end
                end
                EXEC_R, EXEC_I, EXEC_U: begin
                    state <= ALUWB;
                end
                ALUWB: begin
                    state   <= FETCH;
                    instret <= instret + CNT_ONE;
                end
                BRANCH: begin
                    if (branch_ok) begin
                        state   <= FETCH;
                        instret <= instret + CNT_ONE;
                    end else begin
                        state <= TRAP;
                    end
                end
                JAL: begin
                    state <= ALUWB;
                end
                TRAP: begin
                    state <= TRAP;
                end
                default: begin
                    state <= TRAP;
                end
            endcase
        end
    end

    // Outputs decode the state; all of them are held low while rst is high so
    // an in-flight access is dropped within the reset cycle itself.
    always_comb begin
        mem_req    = 1'b0;
        MemWrite   = 1'b0;
        AdrSrc     = 1'b0;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        RegWrite   = 1'b0;
        ImmSrc     = IMM_I;
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_RD2;
        ALUcontrol = ALU_ADD;
        ResultSrc  = RES_ALUOUT;
        halted     = 1'b0;
        if (!rst) begin
            case (state)
                FETCH: begin
                    mem_req   = 1'b1;
                    ALUSrcA   = SRCA_PC;
                    ALUSrcB   = SRCB_FOUR;
                    ResultSrc = RES_ALU;
                    IRWrite   = mem_ready;
                    PCWrite   = mem_ready;
                end
                DECODE: begin
                    ALUSrcA = SRCA_OLDPC;
                    ALUSrcB = SRCB_IMM;
                    ImmSrc  = IMM_B;
                end
                MEMADR: begin
                    ALUSrcA = SRCA_RD1;
                    ALUSrcB = SRCB_IMM;
                    ImmSrc  = (op == OP_STORE) ? IMM_S : IMM_I;
                end
                MEMREAD: begin
                    mem_req = 1'b1;
                    AdrSrc  = 1'b1;
                end
                MEMWB: begin
                    ResultSrc = RES_MEM;
                    RegWrite  = 1'b1;
                end
                MEMWRITE: begin
                    mem_req  = 1'b1;
                    MemWrite = 1'b1;
                    AdrSrc   = 1'b1;
                end
                EXEC_R: begin
                    ALUSrcA    = SRCA_RD1;
                    ALUSrcB    = SRCB_RD2;
                    ALUcontrol = alu_decode(funct3, funct7);
                end
                EXEC_I: begin
                    ALUSrcA    = SRCA_RD1;
                    ALUSrcB    = SRCB_IMM;
                    ImmSrc     = IMM_I;
                    // funct7 is part of the immediate except for shifts-right.
                    ALUcontrol = alu_decode(funct3, funct7 && (funct3 == 3'b101));
                end
                EXEC_U: begin
                    ALUSrcA = SRCA_ZERO;
                    ALUSrcB = SRCB_IMM;
                    ImmSrc  = IMM_U;
                end
                ALUWB: begin
                    ResultSrc = RES_ALUOUT;
                    RegWrite  = 1'b1;
                end
                BRANCH: begin
                    ALUSrcA    = SRCA_RD1;
                    ALUSrcB    = SRCB_RD2;
                    ALUcontrol = ALU_SUB;
                    ResultSrc  = RES_ALUOUT;
                    PCWrite    = taken;
                end
                JAL: begin
                    ALUSrcA   = SRCA_OLDPC;
                    ALUSrcB   = SRCB_FOUR;
                    ResultSrc = RES_ALUOUT;
                    PCWrite   = 1'b1;
                end
                TRAP: begin
                    halted = 1'b1;
                end
                default: begin
                    halted = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl
// Scoreboard bench for multicycle_ctrl. A transaction-level model expands each
// instruction into its expected per-cycle control words and pushes them; a
// monitor on the falling edge pops and compares against the DUT outputs.
// ---------------------------------------------------------------------------
module tb_multicycle_ctrl;

    localparam int unsigned WAIT_MAX = 15;
    localparam int unsigned CW       = 4;
    localparam int unsigned VW       = 20 + CW;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // ALU code for each funct3 in its base flavour; the alternate flavour
    // (sub, sra) is the next code up.
    localparam logic [3:0] ALU_BASE [8] = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [6:0]    op = '0;
    logic [2:0]    funct3 = '0;
    logic          funct7 = 1'b0;
    logic          zero = 1'b0;
    logic          negative = 1'b0;
    logic          mem_ready = 1'b0;
    logic          mem_req;
    logic          MemWrite;
    logic          AdrSrc;
    logic          IRWrite;
    logic          PCWrite;
    logic          RegWrite;
    logic [2:0]    ImmSrc;
    logic [1:0]    ALUSrcA;
    logic [1:0]    ALUSrcB;
    logic [3:0]    ALUcontrol;
    logic [1:0]    ResultSrc;
    logic          halted;
    logic [CW-1:0] instret;

    always #5 clk = ~clk;

    multicycle_ctrl #(.MEM_WAIT_MAX(WAIT_MAX), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7(funct7),
        .zero(zero), .negative(negative), .mem_ready(mem_ready),
        .mem_req(mem_req), .MemWrite(MemWrite), .AdrSrc(AdrSrc),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite),
        .ImmSrc(ImmSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUcontrol(ALUcontrol), .ResultSrc(ResultSrc), .halted(halted),
        .instret(instret)
    );

    typedef struct {
        string          tag;
        logic [VW-1:0]  word;
    } exp_t;

    exp_t        sbq[$];
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned model_cnt = 0;
    bit          trapped = 1'b0;
    logic [3:0]  cur_alu = '0;
    logic [2:0]  cur_imm = '0;
    logic        cur_tk = 1'b0;

    function automatic logic [3:0] alu_ref(input logic [2:0] f3, input logic alt);
        logic [3:0] code;
        code = ALU_BASE[f3];
        if (alt && (f3 == 3'b000 || f3 == 3'b101)) code = code + 4'd1;
        return code;
    endfunction

    function automatic logic branch_ref(input logic [2:0] f3, input logic z, input logic n,
                                        output bit ok);
        ok = 1'b1;
        if (f3 == 3'b000) return z;          // beq
        if (f3 == 3'b001) return !z;         // bne
        if (f3 == 3'b100) return n;          // blt
        if (f3 == 3'b101) return !n;         // bge
        ok = 1'b0;
        return 1'b0;
    endfunction

    // Expected control word of one cycle of the named phase.
    function automatic logic [VW-1:0] expect_word(input string ph, input logic rdy,
                                                  input int unsigned cnt);
        logic mr, mw, as, ir, pw, rw, h;
        logic [2:0] im;
        logic [1:0] a, b, rs;
        logic [3:0] al;
        logic [CW-1:0] c;
        {mr, mw, as, ir, pw, rw, h} = '0;
        im = '0; a = '0; b = '0; rs = '0; al = '0;
        c = CW'(cnt);
        case (ph)
            "FETCH":    begin mr = 1; b = 2'b10; rs = 2'b10; ir = rdy; pw = rdy; end
            "DECODE":   begin a = 2'b01; b = 2'b01; im = 3'b010; end
            "MEMADR":   begin a = 2'b10; b = 2'b01; im = cur_imm; end
            "MEMREAD":  begin mr = 1; as = 1; end
            "MEMWB":    begin rs = 2'b01; rw = 1; end
            "MEMWRITE": begin mr = 1; mw = 1; as = 1; end
            "EXEC_R":   begin a = 2'b10; b = 2'b00; al = cur_alu; end
            "EXEC_I":   begin a = 2'b10; b = 2'b01; al = cur_alu; end
            "EXEC_U":   begin a = 2'b11; b = 2'b01; im = 3'b100; end
            "ALUWB":    begin rw = 1; end
            "BRANCH":   begin a = 2'b10; al = 4'b0001; pw = cur_tk; end
            "JAL":      begin a = 2'b01; b = 2'b10; pw = 1; end
            "TRAP":     begin h = 1; end
            default:    begin c = '0; end
        endcase
        return {mr, mw, as, ir, pw, rw, im, a, b, al, rs, h, c};
    endfunction

    task automatic step(input string ph, input logic rdy);
        exp_t e;
        mem_ready = rdy;
        e.tag  = ph;
        e.word = expect_word(ph, rdy, model_cnt);
        sbq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic mem_phase(input string ph, input int unsigned d);
        if (d <= WAIT_MAX) begin
            for (int unsigned i = 0; i < d; i++) step(ph, 1'b0);
            step(ph, 1'b1);
        end else begin
            for (int unsigned i = 0; i <= WAIT_MAX; i++) step(ph, 1'b0);
            trapped = 1'b1;
        end
    endtask

    task automatic retire();
        model_cnt = (model_cnt + 1) % (1 << CW);
    endtask

    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                             input logic z, input logic n,
                             input int unsigned fd, input int unsigned md);
        bit ok;
        op = o; funct3 = f3; funct7 = f7; zero = z; negative = n;
        cur_alu = '0; cur_imm = '0; cur_tk = 1'b0;
        mem_phase("FETCH", fd);
        if (trapped) return;
        step("DECODE", 1'($urandom_range(0, 1)));
        case (o)
            OP_LOAD: begin
                cur_imm = 3'b000;
                step("MEMADR", 1'($urandom_range(0, 1)));
                mem_phase("MEMREAD", md);
                if (trapped) return;
                step("MEMWB", 1'($urandom_range(0, 1)));
                retire();
            end
            OP_STORE: begin
                cur_imm = 3'b001;
                step("MEMADR", 1'($urandom_range(0, 1)));
                mem_phase("MEMWRITE", md);
                if (!trapped) retire();
            end
            OP_R: begin
                cur_alu = alu_ref(f3, f7);
                step("EXEC_R", 1'($urandom_range(0, 1)));
                step("ALUWB", 1'($urandom_range(0, 1)));
                retire();
            end
            OP_I: begin
                cur_alu = alu_ref(f3, f7 && (f3 == 3'b101));
                step("EXEC_I", 1'($urandom_range(0, 1)));
                step("ALUWB", 1'($urandom_range(0, 1)));
                retire();
            end
            OP_LUI: begin
                step("EXEC_U", 1'($urandom_range(0, 1)));
                step("ALUWB", 1'($urandom_range(0, 1)));
                retire();
            end
            OP_BRANCH: begin
                cur_tk = branch_ref(f3, z, n, ok);
                step("BRANCH", 1'($urandom_range(0, 1)));
                if (ok) retire();
                else trapped = 1'b1;
            end
            OP_JAL: begin
                step("JAL", 1'($urandom_range(0, 1)));
                step("ALUWB", 1'($urandom_range(0, 1)));
                retire();
            end
            default: trapped = 1'b1;
        endcase
    endtask

    task automatic hold_trap(input int unsigned cycles);
        for (int unsigned i = 0; i < cycles; i++) step("TRAP", 1'($urandom_range(0, 1)));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_cnt = 0;
        step("RESET", 1'($urandom_range(0, 1)));
        rst = 1'b0;
        trapped = 1'b0;
    endtask

    function automatic int unsigned rand_delay();
        if ($urandom_range(0, 11) == 0) return $urandom_range(14, 16);
        return $urandom_range(0, 3);
    endfunction

    // Monitor: every cycle with an expectation queued is compared mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        logic [VW-1:0] got;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            got = {mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, ImmSrc,
                   ALUSrcA, ALUSrcB, ALUcontrol, ResultSrc, halted, instret};
            n_cmp++;
            if (got !== e.word) begin
                n_bad++;
                $display("FAIL %s @%0t: got %h required %h", e.tag, $time, got, e.word);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [6:0] o;
        logic [2:0] f3;
        int unsigned pick;
        @(posedge clk);
        #1;
        do_reset();

        // Directed cases
        run_instr(OP_R, 3'b000, 1'b0, 1'b0, 1'b0, 0, 0);       // add
        run_instr(OP_LOAD, 3'b010, 1'b0, 1'b0, 1'b0, 0, 3);    // lw, 3 wait cycles
        run_instr(OP_BRANCH, 3'b000, 1'b0, 1'b1, 1'b0, 0, 0);  // beq taken
        run_instr(OP_BRANCH, 3'b001, 1'b0, 1'b1, 1'b0, 0, 0);  // bne not taken
        run_instr(OP_BRANCH, 3'b100, 1'b0, 1'b0, 1'b1, 0, 0);  // blt taken
        run_instr(OP_R, 3'b101, 1'b1, 1'b0, 1'b0, 1, 0);       // sra
        run_instr(OP_I, 3'b000, 1'b1, 1'b0, 1'b0, 0, 0);       // addi ignores funct7
        run_instr(OP_LUI, 3'b000, 1'b0, 1'b0, 1'b0, 0, 0);
        run_instr(OP_JAL, 3'b000, 1'b0, 1'b0, 1'b0, 0, 0);
        run_instr(OP_STORE, 3'b010, 1'b0, 1'b0, 1'b0, 2, 15); // ready at the limit
        run_instr(OP_R, 3'b000, 1'b0, 1'b0, 1'b0, 15, 0);     // fetch ready at the limit

        // Illegal opcode
        run_instr(7'b1111111, 3'b000, 1'b0, 1'b0, 1'b0, 0, 0);
        hold_trap(100);
        do_reset();

        // Fetch timeout
        run_instr(OP_R, 3'b000, 1'b0, 1'b0, 1'b0, 16, 0);
        hold_trap(4);
        do_reset();

        // Reset while a store waits on memory
        run_instr(OP_R, 3'b111, 1'b0, 1'b0, 1'b0, 0, 0);
        op = OP_STORE;
        cur_imm = 3'b001;
        step("FETCH", 1'b1);
        step("DECODE", 1'b0);
        step("MEMADR", 1'b0);
        step("MEMWRITE", 1'b0);
        step("MEMWRITE", 1'b0);
        do_reset();
        run_instr(OP_R, 3'b000, 1'b0, 1'b0, 1'b0, 0, 0);

        // Random instruction stream
        for (int unsigned k = 0; k < 300; k++) begin
            pick = $urandom_range(0, 19);
            f3 = 3'($urandom_range(0, 7));
            case (pick)
                0, 1, 2:     o = OP_LOAD;
                3, 4, 5:     o = OP_STORE;
                6, 7, 8:     o = OP_R;
                9, 10, 11:   o = OP_I;
                12, 13:      o = OP_LUI;
                14, 15, 16:  o = OP_BRANCH;
                17, 18:      o = OP_JAL;
                default:     o = 7'($urandom_range(0, 127));
            endcase
            if (o == OP_BRANCH && $urandom_range(0, 7) != 0) begin
                pick = $urandom_range(0, 3);
                f3 = (pick == 0) ? 3'b000 : (pick == 1) ? 3'b001 : (pick == 2) ? 3'b100 : 3'b101;
            end
            run_instr(o, f3, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), rand_delay(), rand_delay());
            if (trapped) begin
                hold_trap($urandom_range(1, 5));
                do_reset();
            end
        end

        @(negedge clk);
        #1;
        if (sbq.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending entries required 0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
